// File: rtl/dac_pkg.sv
// Shared definitions for the serial DAC front end: frame layout, FSM states
// and the DAC power-down command encodings.
package dac_pkg;

  localparam int unsigned CMD_W        = 2;
  localparam int unsigned PAD_W        = 2;
  localparam int unsigned SAMPLE_W_DEF = 12;
  localparam int unsigned FRAME_W      = CMD_W + SAMPLE_W_DEF + PAD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } dac_state_e;

  localparam logic [CMD_W-1:0] CMD_NORMAL  = 2'b00;
  localparam logic [CMD_W-1:0] CMD_PD_1K   = 2'b01;
  localparam logic [CMD_W-1:0] CMD_PD_100K = 2'b10;
  localparam logic [CMD_W-1:0] CMD_PD_HIZ  = 2'b11;

  // Frame length for a given sample width: command bits, sample, trailing pad.
  function automatic int unsigned frame_width(input int unsigned data_w);
    return CMD_W + data_w + PAD_W;
  endfunction

endpackage

// File: rtl/dac_bit_timer.sv
// SCLK generator: a half-period counter that toggles SCLK every CLK_DIV
// cycles while enabled. SCLK idles high; clr restarts a bit period with SCLK
// high. The tick strobes flag the edge on which SCLK will rise or fall.
module dac_bit_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_sclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int unsigned     CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_tc;

  assign w_tc        = (r_cnt == CNT_MAX);
  assign o_fall_tick = i_en & w_tc & r_sclk;
  assign o_rise_tick = i_en & w_tc & ~r_sclk;
  assign o_sclk      = r_sclk;

  // Half-period count and SCLK toggle at terminal count.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (i_en) begin
      if (w_tc) begin
        r_cnt  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serial DAC front end. Captures {daccmd, sample, pad} on a dacdav rising
// edge, shifts it MSB first over a 3-wire SPI link, pulses davdac when the
// frame is written, then holds SYNC high for a short gap.
//
//   state | meaning
//   IDLE  | waiting for a request (new edge or queued one)
//   SHIFT | frame on the wire, dac_sync_n low
//   DONE  | one-cycle davdac pulse
//   GAP   | CLK_DIV cycles of SYNC high before the next frame may start
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dacdav,
  input  logic [CMD_W-1:0]  daccmd,
  input  logic [DATA_W-1:0] sample,
  output logic              davdac,
  output logic              busy,
  output logic              dac_sync_n,
  output logic              dac_sclk,
  output logic              dac_sdin
);

  localparam int unsigned      FRAME_LEN = frame_width(DATA_W);
  localparam int unsigned      BIT_W     = $clog2(FRAME_LEN);
  localparam logic [BIT_W-1:0] BIT_MAX   = BIT_W'(FRAME_LEN - 1);
  localparam int unsigned      GAP_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  dac_state_e r_state;
  dac_state_e w_nxt_state;

  logic                 r_dacdav_q;
  logic                 r_pend;
  logic [FRAME_LEN-2:0] r_shift;
  logic [BIT_W-1:0]     r_bit;
  logic                 r_last;
  logic [GAP_W-1:0]     r_gap;
  logic                 r_sync_n;
  logic                 r_sdin;
  logic                 r_davdac;
  logic                 r_busy;

  logic                 w_start;
  logic                 w_go;
  logic                 w_load;
  logic                 w_done;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_sclk;
  logic                 w_timer_en;
  logic [FRAME_LEN-1:0] w_frame;

  assign w_frame    = {daccmd, sample, {PAD_W{1'b0}}};
  assign w_start    = dacdav & ~r_dacdav_q;
  assign w_go       = w_start | r_pend;
  assign w_timer_en = (r_state == SHIFT);
  // r_last is set once the DAC has sampled the final bit, so the next SCLK
  // rise closes the frame.
  assign w_done     = w_rise & r_last;

  dac_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_timer_en),
    .i_clr      (w_load),
    .o_sclk     (w_sclk),
    .o_rise_tick(w_rise),
    .o_fall_tick(w_fall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt_state;
  end

  // Next state and frame-load decision. A queued request leaves GAP directly
  // into SHIFT on the edge where IDLE would otherwise be re-entered.
  always_comb begin
    w_nxt_state = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_nxt_state = SHIFT;
          w_load      = 1'b1;
        end
      end
      SHIFT: begin
        if (w_done) w_nxt_state = DONE;
      end
      DONE: begin
        w_nxt_state = GAP;
      end
      GAP: begin
        if (r_gap == '0) begin
          if (w_go) begin
            w_nxt_state = SHIFT;
            w_load      = 1'b1;
          end else begin
            w_nxt_state = IDLE;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // Request edge detect and single-entry queue. dacdav_q resets high so a
  // level held through reset is not mistaken for a new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dacdav_q <= 1'b1;
      r_pend     <= 1'b0;
    end else begin
      r_dacdav_q <= dacdav;
      if (w_load)                           r_pend <= 1'b0;
      else if (w_start && r_state != IDLE)  r_pend <= 1'b1;
    end
  end

  // Shift register, bit counter and registered SPI/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_bit    <= '0;
      r_last   <= 1'b0;
      r_sync_n <= 1'b1;
      r_sdin   <= 1'b0;
      r_davdac <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_sync_n <= (w_nxt_state != SHIFT);
      r_davdac <= (w_nxt_state == DONE);
      r_busy   <= (w_nxt_state != IDLE);
      if (w_load) begin
        r_shift <= w_frame[FRAME_LEN-2:0];
        r_sdin  <= w_frame[FRAME_LEN-1];
        r_bit   <= '0;
        r_last  <= 1'b0;
      end else if (r_state == SHIFT) begin
        if (w_rise) begin
          r_shift <= {r_shift[FRAME_LEN-3:0], 1'b0};
          r_sdin  <= w_done ? 1'b0 : r_shift[FRAME_LEN-2];
          r_bit   <= w_done ? '0 : r_bit + BIT_W'(1);
          r_last  <= 1'b0;
        end else if (w_fall && r_bit == BIT_MAX) begin
          r_last <= 1'b1;
        end
      end
    end
  end

  // SYNC-high gap as a down-counter loaded while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap <= '0;
    end else if (r_state == DONE) begin
      r_gap <= GAP_W'(CLK_DIV - 1);
    end else if (r_state == GAP && r_gap != '0) begin
      r_gap <= r_gap - GAP_W'(1);
    end
  end

  assign davdac     = r_davdac;
  assign busy       = r_busy;
  assign dac_sync_n = r_sync_n;
  assign dac_sclk   = w_sclk;
  assign dac_sdin   = r_sdin;

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial DAC front end for the TX chain. Sits directly downstream of the TX sequencing controller: it accepts one DDS sample per `dacdav` request, shifts it with a 2-bit power-down command into a 3-wire SPI DAC, and returns a one-cycle `davdac` when the frame has been written. It has no knowledge of tone generation; it only frames and serializes.

## Interface
- `DATA_W`, 12: sample width.
- `CLK_DIV`, 4: SCLK half-period in `clk` cycles, ≥1.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dacdav` in 1: write request from the controller; level signal, acted on at its rising edge.
- `daccmd` in 2: DAC power-down command; 00 = normal.
- `sample` in DATA_W: DDS sample, offset-binary.
- `davdac` out 1: one-cycle pulse when the frame is complete.
- `busy` out 1: high in every state except IDLE.
- `dac_sync_n` out 1: SPI frame strobe, active low.
- `dac_sclk` out 1: SPI clock; idles high.
- `dac_sdin` out 1: SPI data, MSB first.

## Operation
- Frame is 16 bits: `{daccmd, sample, 2'b00}` (FRAME_W = 2 + DATA_W + 2).
- Edge detect: `dacdav_q` registers `dacdav`. Start = `dacdav & ~dacdav_q`. `dacdav_q` resets to 1, so a `dacdav` held high through reset never starts a frame.
- Pending bit: a start seen outside IDLE sets `pend`. At most one request is queued; further edges while `pend` = 1 are dropped.
- FSM states:
  - IDLE → SHIFT on (start | pend). Clears `pend`. Captures `daccmd` and `sample` into the shift register on that edge.
  - SHIFT: runs 16 bit periods, then → DONE.
  - DONE: lasts one cycle, `davdac` = 1, then → GAP.
  - GAP: lasts CLK_DIV cycles with `dac_sync_n` high (DAC minimum SYNC-high time), then → IDLE.
- Bit period is 2·CLK_DIV cycles. `dac_sclk` is high for CLK_DIV cycles, then low for CLK_DIV cycles. `dac_sdin` changes only at the rising SCLK transition, and the DAC samples it on the falling transition.
- Counters:
  - half-period counter 0..CLK_DIV-1.
  - bit counter 0..15; wraps to 0 on leaving SHIFT.
- Reset values: `dac_sync_n` = 1, `dac_sclk` = 1, `dac_sdin` = 0, `davdac` = 0, `busy` = 0, `pend` = 0, state IDLE.
- Reset mid-frame aborts the frame immediately. All outputs return to their reset values on the next edge, with no `davdac`. The DAC ignores the truncated frame because SYNC rises before bit 16.

## Timing
- Let edge T be the one where start is detected in IDLE. At T:
  - `dac_sync_n` ← 0,
  - `dac_sclk` ← 1,
  - `dac_sdin` ← frame[15],
  - `busy` ← 1.
- Bit k is driven from T + 2k·CLK_DIV. SCLK falls at T + (2k+1)·CLK_DIV.
- At T + 32·CLK_DIV:
  - `dac_sync_n` ← 1,
  - `dac_sclk` ← 1,
  - `dac_sdin` ← 0,
  - `davdac` ← 1 for exactly one cycle.
- With CLK_DIV = 4, `davdac` comes 128 cycles after T.
- IDLE is re-entered at T + 33·CLK_DIV + 1 (T + 133 with CLK_DIV = 4). A pending request starts on that edge.
- The controller keeps `dacdav` high for one cycle after seeing `davdac`. No retrigger results, because no new rising edge occurs.
- Sample/cmd changes after T have no effect on the current frame.

## Structure
- Package `dac_pkg`:
  - FRAME_W and the pad width;
  - state enum {IDLE, SHIFT, DONE, GAP};
  - command constants CMD_NORMAL = 00, CMD_PD_1K = 01, CMD_PD_100K = 10, CMD_PD_HIZ = 11.
- One sub-module, `dac_bit_timer`: the half-period counter plus SCLK generation. It outputs `rise_tick` and `fall_tick` strobes and has `en`/`clr` inputs. The FSM and shift register stay in `dac_spi_tx`.

## Test plan
- After reset, `dacdav` 0→1 with `sample` = 12'hA5C and `daccmd` = 00 (CLK_DIV = 4):
  - shifted frame = 16'h2970 MSB first, sampled on SCLK falling edges;
  - `dac_sync_n` low exactly 128 cycles;
  - `davdac` a single pulse at T+128.
- `daccmd` = 11 and `sample` = 12'hFFF → frame 16'hFFFC. `busy` is high from T to T+132 inclusive.
- Closed loop against a behavioural model of the controller over 10 requests → exactly 10 frames and 10 `davdac` pulses, with no extra frame from the trailing `dacdav` high cycle.
- Second rising edge of `dacdav` at bit 5 with a different sample → second frame starts at T+133, carrying the sample present at T+133. A third edge during the first frame is dropped.
- `rst` asserted at bit 7 with `dacdav` held high → next cycle `dac_sync_n` = 1, `dac_sclk` = 1, `dac_sdin` = 0, no `davdac`. No frame starts until `dacdav` goes low then high.
- CLK_DIV = 1 → SCLK toggles every cycle, `dac_sync_n` is low for 32 cycles, and the GAP lasts 1 cycle.
